// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl -- instruction memory loader and sequential fetch controller.
//
// The block first streams a program into an external instruction memory
// (LOAD). A start pulse then fetches from it word by word (RUN). Fetch can be
// stalled or redirected. A misaligned redirect parks the controller in HALT,
// and only reset leaves HALT.
//
// Optional feature (macro FETCH_CTRL_HALT_DETECT_EN):
//   When defined, a fetched word equal to 32'hFFFFFFFF is presented as a
//   valid instruction, and the FSM enters HALT on the following edge.
//   When undefined, that word is treated like any other instruction.
//
// Parameters:
//   DEPTH    : number of 32-bit words in the instruction memory (>= 2)
//   RESET_PC : byte address where RUN starts
//
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   load_valid/load_ready            : loader handshake
//   load_data/load_last              : program word and final-word marker
//   start                            : one-cycle pulse that begins execution
//   stall/br_taken/br_target         : PC hold, redirect, redirect address
//   mem_we/mem_addr/mem_wdata        : instruction memory write port/address
//   mem_rdata                        : combinational read data for mem_addr
//   pc/instr/instr_valid             : fetch address, fetched word, valid
//   state_o/halted/err_misaligned    : FSM state, HALT flag, sticky error
//
// Handshake: a load word transfers on every rising edge where load_valid and
// load_ready are both 1. load_ready is 1 only in LOAD, and it does not depend
// on load_valid. load_valid may be held high across back-to-back words.
// ---------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int          DEPTH    = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [31:0]              load_data,
    input  logic                     load_last,
    input  logic                     start,
    input  logic                     stall,
    input  logic                     br_taken,
    input  logic [31:0]              br_target,
    output logic                     mem_we,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata,
    output logic [31:0]              pc,
    output logic [31:0]              instr,
    output logic                     instr_valid,
    output logic [1:0]               state_o,
    output logic                     halted,
    output logic                     err_misaligned
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t        state;
    logic [31:0]   pc_q;
    logic [AW-1:0] load_cnt;
    logic          err_q;

    logic          in_load;
    logic          in_run;
    logic          fetch_ok;
    logic          halt_word;

    assign in_load = (state == ST_LOAD);
    assign in_run  = (state == ST_RUN);

    // A redirect outranks a stall, so the current word is still presented
    // as valid in a cycle where both are requested.
    assign fetch_ok = in_run && (br_taken || !stall);

`ifdef FETCH_CTRL_HALT_DETECT_EN
    assign halt_word = fetch_ok && (mem_rdata == 32'hFFFF_FFFF);
`else
    assign halt_word = 1'b0;
`endif

    // The memory port is shared. It uses the load counter while loading and
    // the PC word index at all other times. Only the word-index bits of the
    // PC are used, so fetch wraps modulo DEPTH.
    assign load_ready     = in_load;
    assign mem_we         = in_load && load_valid;
    assign mem_wdata      = load_data;
    assign mem_addr       = in_load ? load_cnt : pc_q[AW+1:2];

    assign instr_valid    = fetch_ok;
    assign instr          = fetch_ok ? mem_rdata : 32'h0;
    assign pc             = pc_q;
    assign state_o        = state;
    assign halted         = (state == ST_HALT);
    assign err_misaligned = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pc_q     <= RESET_PC;
            load_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_valid) begin
                        state <= ST_LOAD;
                    end else if (start) begin
                        state <= ST_RUN;
                        pc_q  <= RESET_PC;
                    end
                end
                ST_LOAD: begin
                    if (load_valid) begin
                        if (load_last || (load_cnt == AW'(DEPTH - 1))) begin
                            state    <= ST_IDLE;
                            load_cnt <= '0;
                        end else begin
                            load_cnt <= load_cnt + AW'(1);
                        end
                    end
                end
                ST_RUN: begin
                    // A halt word freezes the PC on the address that
                    // presented it.
                    if (halt_word) begin
                        state <= ST_HALT;
                    end else if (br_taken) begin
                        if (br_target[1:0] != 2'b00) begin
                            err_q <= 1'b1;
                            state <= ST_HALT;
                        end else begin
                            pc_q <= br_target;
                        end
                    end else if (!stall) begin
                        pc_q <= pc_q + 32'd4;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl -- self-checking bench for fetch_ctrl.
// The driver pushes the expected memory writes and fetches into queues.
// A monitor on the falling edge pops and compares them whenever the DUT
// raises mem_we or instr_valid. Registered state is checked directly by the
// driver 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk;
    logic          rst_n;
    logic          load_valid;
    logic          load_ready;
    logic [31:0]   load_data;
    logic          load_last;
    logic          start;
    logic          stall;
    logic          br_taken;
    logic [31:0]   br_target;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic          instr_valid;
    logic [1:0]    state_o;
    logic          halted;
    logic          err_misaligned;

    fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_data      (load_data),
        .load_last      (load_last),
        .start          (start),
        .stall          (stall),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .pc             (pc),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .state_o        (state_o),
        .halted         (halted),
        .err_misaligned (err_misaligned)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instruction memory (environment) ----------------
    logic [31:0] mem [0:DEPTH-1];
    bit          mem_cleared = 1'b0;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (!mem_cleared) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
            mem_cleared <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_wr_q[$];
    logic [63:0] exp_fetch_q[$];
    logic [31:0] img  [0:DEPTH-1];   // expected memory image
    logic [31:0] prog [0:DEPTH-1];   // words for the next load

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every presented write / fetch with the queue head.
    always @(negedge clk) begin
        logic [63:0] e;
        if (mem_we) begin
            if (exp_wr_q.size() == 0) begin
                check("unexpected_write", {32'(mem_addr), mem_wdata}, 64'h0);
                if ({32'(mem_addr), mem_wdata} == 64'h0) begin
                    errors++;
                    $display("FAIL unexpected_write: got write to 0 expected none");
                end
            end else begin
                e = exp_wr_q.pop_front();
                check("mem_write", {32'(mem_addr), mem_wdata}, e);
            end
        end
        if (instr_valid) begin
            if (exp_fetch_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fetch: got pc %0h instr %0h expected none",
                         pc, instr);
            end else begin
                e = exp_fetch_q.pop_front();
                check("fetch", {pc, instr}, e);
            end
        end else begin
            check("instr_zero_when_invalid", {32'h0, instr}, 64'h0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic push_fetch(input logic [31:0] p);
        exp_fetch_q.push_back({p, img[p[AW+1:2]]});
    endtask

    task automatic load_prog(input int n, input bit use_last);
        load_valid = 1'b1;
        load_data  = prog[0];
        load_last  = 1'b0;
        cyc();                                   // IDLE -> LOAD, no transfer
        check("load_enter", {62'h0, state_o}, 64'd1);
        for (int i = 0; i < n; i++) begin
            load_data = prog[i];
            load_last = use_last && (i == n - 1);
            exp_wr_q.push_back({32'(i), prog[i]});
            img[i] = prog[i];
            if (i == 0) check("load_ready", {63'h0, load_ready}, 64'd1);
            cyc();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("load_exit_idle", {62'h0, state_o}, 64'd0);
    endtask

    task automatic start_run;
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("run_enter", {62'h0, state_o}, 64'd2);
        check("run_pc_reset", {32'h0, pc}, 64'h0);
    endtask

    // Reset lands mid-cycle, so its effect is checked before any edge.
    task automatic do_reset_async;
        #2 rst_n = 1'b0;
        #1;
        check("rst_state", {62'h0, state_o}, 64'd0);
        check("rst_pc", {32'h0, pc}, 64'h0);
        check("rst_err", {63'h0, err_misaligned}, 64'd0);
        check("rst_instr_valid", {63'h0, instr_valid}, 64'd0);
        check("rst_mem_we", {63'h0, mem_we}, 64'd0);
        cyc();
        rst_n = 1'b1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- main stimulus ----------------
    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = 32'h0;
        load_last  = 1'b0;
        start      = 1'b0;
        stall      = 1'b0;
        br_taken   = 1'b0;
        br_target  = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            img[i]  = 32'h0;
            prog[i] = 32'h0;
        end
        cyc();
        cyc();
        check("reset_state", {62'h0, state_o}, 64'd0);
        check("reset_pc", {32'h0, pc}, 64'h0);
        check("reset_halted", {63'h0, halted}, 64'd0);
        check("reset_err", {63'h0, err_misaligned}, 64'd0);
        check("reset_load_ready", {63'h0, load_ready}, 64'd0);
        rst_n = 1'b1;
        cyc();

        // Four words with load_last on the fourth: writes at addresses 0..3.
        prog[0] = 32'h0A0B_0C00;
        prog[1] = 32'h1122_3344;
        prog[2] = 32'hDEAD_BEEF;
        prog[3] = 32'h00C0_FFEE;
        load_prog(4, 1'b1);

        // Sequential fetch of PC 0,4,8,12.
        start_run();
        for (int i = 0; i < 4; i++) begin
            push_fetch(32'(4 * i));
            cyc();
        end
        check("pc_after_4", {32'h0, pc}, 64'h10);

        // Stall holds the PC, then a redirect beats a stall.
        stall = 1'b1;
        cyc();
        check("stall_hold_pc", {32'h0, pc}, 64'h10);
        br_taken  = 1'b1;
        br_target = 32'h8;
        push_fetch(32'h10);
        cyc();
        stall    = 1'b0;
        br_taken = 1'b0;
        check("branch_pc", {32'h0, pc}, 64'h8);
        push_fetch(32'h8);
        cyc();
        check("pc_after_branch", {32'h0, pc}, 64'hC);

        // A misaligned redirect sets the error and halts with the PC frozen.
        br_taken  = 1'b1;
        br_target = 32'h6;
        push_fetch(32'hC);
        cyc();
        br_taken = 1'b0;
        check("misalign_err", {63'h0, err_misaligned}, 64'd1);
        check("misalign_halted", {63'h0, halted}, 64'd1);
        check("misalign_state", {62'h0, state_o}, 64'd3);
        check("misalign_pc", {32'h0, pc}, 64'hC);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        check("halt_sticky_state", {62'h0, state_o}, 64'd3);
        check("halt_pc_frozen", {32'h0, pc}, 64'hC);
        do_reset_async();

        // DEPTH words without load_last, then run across the wrap point.
        for (int i = 0; i < DEPTH; i++) prog[i] = 32'hA500_0000 + 32'(i) * 32'h0001_0001;
        load_prog(DEPTH, 1'b0);
        start_run();
        for (int i = 0; i < 34; i++) begin
            if (i == 31) check("addr_at_7c", {59'h0, mem_addr}, 64'd31);
            if (i == 32) check("addr_wrap_80", {59'h0, mem_addr}, 64'd0);
            push_fetch(32'(4 * i));
            cyc();
        end
        check("pc_after_wrap", {32'h0, pc}, 64'h88);
        do_reset_async();

        // Memory contents survive reset; the program runs again.
        start_run();
        push_fetch(32'h0);
        cyc();
        push_fetch(32'h4);
        cyc();
        do_reset_async();

        // Reset after two load transfers, then a fresh load starts at 0.
        prog[0] = 32'h5555_0000;
        prog[1] = 32'h5555_0001;
        load_valid = 1'b1;
        load_data  = prog[0];
        cyc();
        for (int i = 0; i < 2; i++) begin
            load_data = prog[i];
            exp_wr_q.push_back({32'(i), prog[i]});
            img[i] = prog[i];
            cyc();
        end
        load_data = 32'h5555_0002;
        do_reset_async();
        load_valid = 1'b0;
        cyc();
        check("idle_after_load_reset", {62'h0, state_o}, 64'd0);

        prog[0] = 32'h600D_0000;
        prog[1] = 32'h600D_0001;
        prog[2] = 32'hFFFF_FFFF;
        prog[3] = 32'h600D_0003;
        load_prog(4, 1'b1);
        start_run();
        push_fetch(32'h0);
        cyc();
        push_fetch(32'h4);
        cyc();
        push_fetch(32'h8);
        cyc();
`ifdef FETCH_CTRL_HALT_DETECT_EN
        check("halt_word_state", {62'h0, state_o}, 64'd3);
        check("halt_word_pc", {32'h0, pc}, 64'h8);
        check("halt_word_no_err", {63'h0, err_misaligned}, 64'd0);
        cyc();
        check("halt_word_pc_frozen", {32'h0, pc}, 64'h8);
`else
        check("ffff_ordinary_state", {62'h0, state_o}, 64'd2);
        check("ffff_ordinary_pc", {32'h0, pc}, 64'hC);
        push_fetch(32'hC);
        cyc();
        check("ffff_ordinary_pc_next", {32'h0, pc}, 64'h10);
`endif
        do_reset_async();

        cyc();
        check("wr_queue_drained", 64'(exp_wr_q.size()), 64'd0);
        check("fetch_queue_drained", 64'(exp_fetch_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
